tank_heading_ctrl: RTL and testbench
====================================

Name: tank_heading_ctrl

Overview:
- Sequences the rotation inputs of the colour mapper's rotated-tank datapath.
- Once per frame, steps the tank heading from the player's rotate buttons.
- Fetches the matching signed Q1.7 sine/cosine pair from the shared trig ROM over a req/ack handshake.
- Commits the pair to the colour mapper's sin2/cos2 inputs atomically during blanking, so no visible line ever sees a mixed pair.

Parameters:
- ANGLE_STEPS, 32, number of heading positions per revolution; power of two, 4..256.
- ANGLE_W, 5, width of the heading index; equals log2(ANGLE_STEPS).
- ROT_DIV, 4, frames per heading step while a button is held; 1..255.

Ports:
- Clk  in  1  system clock; the only clock.
- Reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  single-cycle pulse once per frame (vsync edge), synchronous to Clk.
- blank  in  1  1 = active display, 0 = blanking; same polarity as the colour mapper's blank.
- rot_left  in  1  level, rotate counter-clockwise (heading index +1).
- rot_right  in  1  level, rotate clockwise (heading index -1).
- rom_req  out  1  trig ROM request.
- rom_addr  out  ANGLE_W  trig ROM address; equals the heading index being fetched.
- rom_ack  in  1  single-cycle ROM acknowledge; rom_sin/rom_cos are valid in the same cycle.
- rom_sin  in  8  signed Q1.7 sine.
- rom_cos  in  8  signed Q1.7 cosine.
- sin2  out  8  registered sine to the colour mapper.
- cos2  out  8  registered cosine to the colour mapper.
- angle  out  ANGLE_W  committed heading index.
- busy  out  1  high in FETCH and COMMIT.
- upd_done  out  1  one-cycle pulse in the commit cycle.

Behaviour:
- Reset values (async, Reset low): state=IDLE, angle=0, pending index=0, frame divider=0, sin2=8'h00, cos2=8'h7F, rom_req=0, rom_addr=0, busy=0, upd_done=0.
- All outputs are registered.
- IDLE:
  - On frame_tick, the divider increments. It wraps to 0 when it reaches ROT_DIV-1; that cycle is the step cycle.
  - Step cycle with rot_left=1, rot_right=0: pending = angle+1 mod ANGLE_STEPS.
  - Step cycle with rot_right=1, rot_left=0: pending = angle-1 mod ANGLE_STEPS.
  - Index wrap-around comes from natural ANGLE_W-bit overflow: max+1 -> 0, 0-1 -> ANGLE_STEPS-1.
  - In either rotate case, the next state is FETCH, with rom_req=1 and rom_addr=pending from the next cycle.
  - Both buttons or neither button on the step cycle: no fetch; the divider still wraps.
- FETCH:
  - rom_req and rom_addr are held stable until rom_ack.
  - On the rom_ack cycle: rom_sin/rom_cos are captured into shadow registers, rom_req drops the next cycle, and the next state is COMMIT.
  - No timeout; FETCH waits indefinitely.
- COMMIT:
  - Waits for the first cycle with blank=0.
  - In that cycle, sin2, cos2 and angle all update on the same edge (shadow -> outputs, pending -> angle), upd_done=1 for exactly one cycle, and the next state is IDLE.
  - If blank is already 0 on COMMIT entry, the commit happens in the first COMMIT cycle.
- Latency: at least 1 cycle from the step tick to rom_req; at least 1 cycle from rom_ack to commit, plus the wait for blanking.
- frame_tick while busy=1: ignored, and the divider does not advance. Its first effect is on the next tick after returning to IDLE.
- rom_ack outside FETCH: ignored, no register change.
- Button changes during FETCH/COMMIT have no effect on the fetch in progress.
- Reset mid-FETCH: rom_req drops asynchronously; the in-flight ROM response is discarded after reset release because the state is IDLE.
- sin2/cos2 never change while blank=1 except through reset.

Test Plan:
- Reset release, ROT_DIV=4, rot_left held, 4 frame_ticks -> rom_req rises 1 cycle after the 4th tick with rom_addr=1. After ack (sin=8'h19, cos=8'h7D) and blank=0 -> sin2=8'h19, cos2=8'h7D, angle=1, one upd_done pulse.
- angle=0, rot_right held through one step -> rom_addr=31. After the commit, angle=31.
- angle=31, rot_left held through one step -> rom_addr=0 (wrap-around).
- Ack arrives with blank=1 held for 50 cycles -> sin2/cos2 unchanged for all 50 cycles; they update on the first blank=0 cycle, with upd_done high for exactly 1 cycle.
- Both buttons held for 8 ticks -> no rom_req, angle stays 0. rom_ack pulsed spuriously in IDLE -> sin2/cos2 stay 00/7F.
- Reset asserted 2 cycles into FETCH, then a late rom_ack with 8'h55 after release -> rom_req=0 immediately, outputs 00/7F, angle=0, no commit.
- frame_tick pulsed during FETCH -> the divider does not advance: with ROT_DIV=4 and a button held, the next step needs 4 ticks after returning to IDLE.

Source files
------------

// File: rtl/tank_heading_ctrl_if.sv
// Trig ROM request/acknowledge bus between the heading controller and the shared sine/cosine ROM.
// The master issues req/addr and the slave answers with a one-cycle ack that carries the Q1.7 pair.
interface tank_heading_ctrl_if #(
    parameter int ANGLE_W = 5
);
    logic               req;
    logic [ANGLE_W-1:0] addr;
    logic               ack;
    logic [7:0]         sine;
    logic [7:0]         cosine;

    modport master (
        output req,
        output addr,
        input  ack,
        input  sine,
        input  cosine
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output sine,
        output cosine
    );
endinterface

// File: rtl/tank_heading_ctrl.sv
// Steps the tank heading once every ROT_DIV frames, fetches the matching sin/cos pair from the trig ROM,
// and commits the pair together with the new heading during blanking so no visible line sees a mixed pair.
module tank_heading_ctrl #(
    parameter int ANGLE_STEPS = 32,
    parameter int ANGLE_W     = 5,
    parameter int ROT_DIV     = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                frame_tick_i,
    input  logic                blank_i,
    input  logic                rot_left_i,
    input  logic                rot_right_i,
    tank_heading_ctrl_if.master rom,
    output logic [7:0]          sin2_o,
    output logic [7:0]          cos2_o,
    output logic [ANGLE_W-1:0]  angle_o,
    output logic                busy_o,
    output logic                upd_done_o
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        COMMIT
    } state_e;

    localparam logic [ANGLE_W-1:0] IDX_MAX  = ANGLE_W'(ANGLE_STEPS - 1);
    localparam logic [ANGLE_W-1:0] IDX_ONE  = ANGLE_W'(1);
    localparam logic [7:0]         DIV_LAST = 8'(ROT_DIV - 1);

    state_e             state_q, state_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic [ANGLE_W-1:0] pend_q, pend_d;
    logic [7:0]         div_q, div_d;
    logic [7:0]         sin_sh_q, sin_sh_d;
    logic [7:0]         cos_sh_q, cos_sh_d;
    logic [7:0]         sin2_q, sin2_d;
    logic [7:0]         cos2_q, cos2_d;
    logic               req_q, req_d;
    logic [ANGLE_W-1:0] addr_q, addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            angle_q  <= '0;
            pend_q   <= '0;
            div_q    <= '0;
            sin_sh_q <= 8'h00;
            cos_sh_q <= 8'h7F;
            sin2_q   <= 8'h00;
            cos2_q   <= 8'h7F;
            req_q    <= 1'b0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            angle_q  <= angle_d;
            pend_q   <= pend_d;
            div_q    <= div_d;
            sin_sh_q <= sin_sh_d;
            cos_sh_q <= cos_sh_d;
            sin2_q   <= sin2_d;
            cos2_q   <= cos2_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        angle_d  = angle_q;
        pend_d   = pend_q;
        div_d    = div_q;
        sin_sh_d = sin_sh_q;
        cos_sh_d = cos_sh_q;
        sin2_d   = sin2_q;
        cos2_d   = cos2_q;
        req_d    = req_q;
        addr_d   = addr_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (frame_tick_i) begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        // Exactly one button must be held; both or neither leaves the heading alone.
                        if (rot_left_i ^ rot_right_i) begin
                            if (rot_left_i) begin
                                pend_d = (angle_q == IDX_MAX) ? '0 : angle_q + IDX_ONE;
                            end else begin
                                pend_d = (angle_q == '0) ? IDX_MAX : angle_q - IDX_ONE;
                            end
                            addr_d  = pend_d;
                            req_d   = 1'b1;
                            state_d = FETCH;
                        end
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
            end
            FETCH: begin
                if (rom.ack) begin
                    sin_sh_d = rom.sine;
                    cos_sh_d = rom.cosine;
                    req_d    = 1'b0;
                    state_d  = COMMIT;
                end
            end
            COMMIT: begin
                // Heading and both trig values move on the same edge, and only outside active display.
                if (!blank_i) begin
                    sin2_d  = sin_sh_q;
                    cos2_d  = cos_sh_q;
                    angle_d = pend_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign rom.req    = req_q;
    assign rom.addr   = addr_q;
    assign sin2_o     = sin2_q;
    assign cos2_o     = cos2_q;
    assign angle_o    = angle_q;
    assign busy_o     = busy_q;
    assign upd_done_o = done_q;

endmodule

// File: tb/tb_tank_heading_ctrl.sv
// Directed bench for tank_heading_ctrl: heading steps, wrap-around, blank-gated commit,
// ignored ticks/acks, and reset in the middle of a ROM fetch.
module tb_tank_heading_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_tick = 1'b0;
    logic       blank = 1'b1;
    logic       rot_left = 1'b0;
    logic       rot_right = 1'b0;
    logic [7:0] sin2;
    logic [7:0] cos2;
    logic [4:0] angle;
    logic       busy;
    logic       upd_done;

    int n_checks = 0;
    int n_pass = 0;

    tank_heading_ctrl_if #(.ANGLE_W(5)) rom_if ();

    tank_heading_ctrl #(
        .ANGLE_STEPS(32),
        .ANGLE_W(5),
        .ROT_DIV(4)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .frame_tick_i(frame_tick),
        .blank_i(blank),
        .rot_left_i(rot_left),
        .rot_right_i(rot_right),
        .rom(rom_if.master),
        .sin2_o(sin2),
        .cos2_o(cos2),
        .angle_o(angle),
        .busy_o(busy),
        .upd_done_o(upd_done)
    );

    always #5 clk = ~clk;

    task automatic pulse_tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic pulse_ack(input logic [7:0] s, input logic [7:0] c);
        rom_if.ack    = 1'b1;
        rom_if.sine   = s;
        rom_if.cosine = c;
        @(negedge clk);
        rom_if.ack    = 1'b0;
        rom_if.sine   = 8'h00;
        rom_if.cosine = 8'h00;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        frame_tick = 1'b0;
        rot_left   = 1'b0;
        rot_right  = 1'b0;
        blank      = 1'b1;
        rom_if.ack = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rom_if.ack    = 1'b0;
        rom_if.sine   = 8'h00;
        rom_if.cosine = 8'h00;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sin2 !== 8'h00) $display("[TB] FAIL reset_sin2: got %h want 00", sin2);
        else n_pass++;
        n_checks++;
        if (cos2 !== 8'h7F) $display("[TB] FAIL reset_cos2: got %h want 7f", cos2);
        else n_pass++;
        n_checks++;
        if (angle !== 5'd0) $display("[TB] FAIL reset_angle: got %0d want 0", angle);
        else n_pass++;
        n_checks++;
        if (rom_if.req !== 1'b0 || rom_if.addr !== 5'd0)
            $display("[TB] FAIL reset_req: got req=%b addr=%0d want req=0 addr=0", rom_if.req, rom_if.addr);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || upd_done !== 1'b0)
            $display("[TB] FAIL reset_flags: got busy=%b done=%b want 0/0", busy, upd_done);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One full step: 4 ticks with the given buttons, ack with blank already low, commit next cycle.
    task automatic test_step_commit(input logic l, input logic r, input logic [4:0] exp_addr,
                                    input logic [7:0] s, input logic [7:0] c, input string tag);
        rot_left  = l;
        rot_right = r;
        repeat (3) pulse_tick();
        n_checks++;
        if (rom_if.req !== 1'b0) $display("[TB] FAIL %s_early_req: got %b want 0", tag, rom_if.req);
        else n_pass++;
        pulse_tick();
        rot_left  = 1'b0;
        rot_right = 1'b0;
        n_checks++;
        if (rom_if.req !== 1'b1 || rom_if.addr !== exp_addr || busy !== 1'b1)
            $display("[TB] FAIL %s_req: got req=%b addr=%0d busy=%b want req=1 addr=%0d busy=1",
                     tag, rom_if.req, rom_if.addr, busy, exp_addr);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (rom_if.req !== 1'b1 || rom_if.addr !== exp_addr)
            $display("[TB] FAIL %s_req_hold: got req=%b addr=%0d want req=1 addr=%0d",
                     tag, rom_if.req, rom_if.addr, exp_addr);
        else n_pass++;
        blank = 1'b0;
        pulse_ack(s, c);
        n_checks++;
        if (rom_if.req !== 1'b0 || upd_done !== 1'b0)
            $display("[TB] FAIL %s_after_ack: got req=%b done=%b want 0/0", tag, rom_if.req, upd_done);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (sin2 !== s || cos2 !== c || angle !== exp_addr || upd_done !== 1'b1)
            $display("[TB] FAIL %s_commit: got sin=%h cos=%h angle=%0d done=%b want sin=%h cos=%h angle=%0d done=1",
                     tag, sin2, cos2, angle, upd_done, s, c, exp_addr);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (upd_done !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL %s_post: got done=%b busy=%b want 0/0", tag, upd_done, busy);
        else n_pass++;
        blank = 1'b1;
    endtask

    task automatic test_first_step();
        test_step_commit(1'b1, 1'b0, 5'd1, 8'h19, 8'h7D, "first_left");
    endtask

    task automatic test_wrap();
        apply_reset();
        test_step_commit(1'b0, 1'b1, 5'd31, 8'h05, 8'h80, "right_wrap");
        test_step_commit(1'b1, 1'b0, 5'd0, 8'h7F, 8'h01, "left_wrap");
    endtask

    task automatic test_blank_hold();
        int bad = 0;
        rot_left = 1'b1;
        repeat (4) pulse_tick();
        rot_left = 1'b0;
        n_checks++;
        if (rom_if.req !== 1'b1 || rom_if.addr !== 5'd1)
            $display("[TB] FAIL blank_req: got req=%b addr=%0d want 1/1", rom_if.req, rom_if.addr);
        else n_pass++;
        blank = 1'b1;
        pulse_ack(8'h19, 8'h7D);
        for (int i = 0; i < 50; i++) begin
            if (sin2 !== 8'h7F || cos2 !== 8'h01 || upd_done !== 1'b0 || angle !== 5'd0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) $display("[TB] FAIL blank_hold: got %0d cycles changed want 0", bad);
        else n_pass++;
        blank = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sin2 !== 8'h19 || cos2 !== 8'h7D || angle !== 5'd1 || upd_done !== 1'b1)
            $display("[TB] FAIL blank_commit: got sin=%h cos=%h angle=%0d done=%b want 19/7d/1/1",
                     sin2, cos2, angle, upd_done);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (upd_done !== 1'b0) $display("[TB] FAIL blank_done_width: got %b want 0", upd_done);
        else n_pass++;
        blank = 1'b1;
    endtask

    task automatic test_both_buttons();
        int reqs = 0;
        apply_reset();
        rot_left  = 1'b1;
        rot_right = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pulse_tick();
            if (rom_if.req !== 1'b0 || busy !== 1'b0) reqs++;
        end
        rot_left  = 1'b0;
        rot_right = 1'b0;
        n_checks++;
        if (reqs != 0) $display("[TB] FAIL both_no_req: got %0d request cycles want 0", reqs);
        else n_pass++;
        n_checks++;
        if (angle !== 5'd0) $display("[TB] FAIL both_angle: got %0d want 0", angle);
        else n_pass++;
        blank = 1'b0;
        pulse_ack(8'h55, 8'h11);
        @(negedge clk);
        n_checks++;
        if (sin2 !== 8'h00 || cos2 !== 8'h7F || upd_done !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL spurious_ack: got sin=%h cos=%h done=%b busy=%b want 00/7f/0/0",
                     sin2, cos2, upd_done, busy);
        else n_pass++;
        blank = 1'b1;
    endtask

    task automatic test_reset_mid_fetch();
        int dones = 0;
        apply_reset();
        rot_left = 1'b1;
        repeat (4) pulse_tick();
        rot_left = 1'b0;
        n_checks++;
        if (rom_if.req !== 1'b1) $display("[TB] FAIL midreset_req_up: got %b want 1", rom_if.req);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rom_if.req !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL midreset_async: got req=%b busy=%b want 0/0", rom_if.req, busy);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        blank = 1'b0;
        @(negedge clk);
        pulse_ack(8'h55, 8'h55);
        for (int i = 0; i < 4; i++) begin
            if (upd_done !== 1'b0) dones++;
            @(negedge clk);
        end
        n_checks++;
        if (sin2 !== 8'h00 || cos2 !== 8'h7F || angle !== 5'd0)
            $display("[TB] FAIL midreset_outputs: got sin=%h cos=%h angle=%0d want 00/7f/0", sin2, cos2, angle);
        else n_pass++;
        n_checks++;
        if (dones != 0 || rom_if.req !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL midreset_no_commit: got dones=%0d req=%b busy=%b want 0/0/0",
                     dones, rom_if.req, busy);
        else n_pass++;
        blank = 1'b1;
    endtask

    task automatic test_tick_during_fetch();
        apply_reset();
        rot_left = 1'b1;
        repeat (4) pulse_tick();
        repeat (2) pulse_tick();
        n_checks++;
        if (rom_if.req !== 1'b1 || rom_if.addr !== 5'd1)
            $display("[TB] FAIL fetchtick_req: got req=%b addr=%0d want 1/1", rom_if.req, rom_if.addr);
        else n_pass++;
        blank = 1'b0;
        pulse_ack(8'h19, 8'h7D);
        repeat (2) @(negedge clk);
        blank = 1'b1;
        n_checks++;
        if (angle !== 5'd1 || busy !== 1'b0)
            $display("[TB] FAIL fetchtick_angle1: got angle=%0d busy=%b want 1/0", angle, busy);
        else n_pass++;
        repeat (3) pulse_tick();
        n_checks++;
        if (rom_if.req !== 1'b0)
            $display("[TB] FAIL fetchtick_div_frozen: got req=%b want 0 after 3 ticks", rom_if.req);
        else n_pass++;
        pulse_tick();
        rot_left = 1'b0;
        n_checks++;
        if (rom_if.req !== 1'b1 || rom_if.addr !== 5'd2)
            $display("[TB] FAIL fetchtick_step2: got req=%b addr=%0d want 1/2", rom_if.req, rom_if.addr);
        else n_pass++;
        blank = 1'b0;
        pulse_ack(8'h31, 8'h76);
        repeat (2) @(negedge clk);
        n_checks++;
        if (angle !== 5'd2 || sin2 !== 8'h31 || cos2 !== 8'h76)
            $display("[TB] FAIL fetchtick_commit2: got angle=%0d sin=%h cos=%h want 2/31/76", angle, sin2, cos2);
        else n_pass++;
        blank = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_wrap();
        test_blank_hold();
        test_both_buttons();
        test_reset_mid_fetch();
        test_tick_during_fetch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
